// File: rtl/instr_register_ctrl_if.sv
// Shared instruction types plus the requester/register/consumer bus.
// master: requesters and consumer; slave: instr_register_ctrl.
package instr_register_pkg;
  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0] address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instr_t;
endpackage

interface instr_register_ctrl_if;
  import instr_register_pkg::*;

  logic     req0_valid;
  logic     req0_ready;
  opcode_t  req0_opcode;
  operand_t req0_operand_a;
  operand_t req0_operand_b;

  logic     req1_valid;
  logic     req1_ready;
  opcode_t  req1_opcode;
  operand_t req1_operand_a;
  operand_t req1_operand_b;

  logic     load_en;
  address_t write_pointer;
  opcode_t  opcode;
  operand_t operand_a;
  operand_t operand_b;

  address_t read_pointer;
  logic     pop_valid;
  logic     pop;
  logic [5:0] count;

  modport master (
    output req0_valid, req0_opcode,
    output req0_operand_a, req0_operand_b,
    input  req0_ready,
    output req1_valid, req1_opcode,
    output req1_operand_a, req1_operand_b,
    input  req1_ready,
    input  load_en, write_pointer, opcode,
    input  operand_a, operand_b,
    input  read_pointer, pop_valid, count,
    output pop
  );

  modport slave (
    input  req0_valid, req0_opcode,
    input  req0_operand_a, req0_operand_b,
    output req0_ready,
    input  req1_valid, req1_opcode,
    input  req1_operand_a, req1_operand_b,
    output req1_ready,
    output load_en, write_pointer, opcode,
    output operand_a, operand_b,
    output read_pointer, pop_valid, count,
    input  pop
  );
endinterface

// File: rtl/instr_register_ctrl.sv
// Write/read controller for the instruction register: arbitrates two
// requesters onto one write port, allocates circular addresses, and
// presents entries to one consumer in FIFO order.
// Ports: clk, reset_n (async, active-low), bus (slave modport):
//   req0/req1 valid/ready/opcode/operand_a/operand_b,
//   load_en/write_pointer/opcode/operand_a/operand_b (write stage),
//   read_pointer/pop_valid/pop/count (consumer side).
// Define INSTR_REGISTER_CTRL_STRICT_PRIO_EN for fixed priority
// (requester 0 wins ties); default is round-robin.
module instr_register_ctrl
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input logic clk,
  input logic reset_n,
  instr_register_ctrl_if.slave bus
);

  localparam address_t LastAddr = address_t'(DEPTH - 1);

  function automatic address_t nxt(address_t a);
    return (a == LastAddr) ? '0 : a + 5'd1;
  endfunction

  address_t   wr_ptr_q, wr_ptr_d;
  address_t   rd_ptr_q, rd_ptr_d;
  logic [5:0] count_q, count_d;
  logic       load_en_q, load_en_d;
  address_t   wp_q, wp_d;
  opcode_t    opc_q, opc_d;
  operand_t   a_q, a_d;
  operand_t   b_q, b_d;

  logic       sel0, sel1;
  logic       full;
  logic       grant0, grant1;
  logic       pop_fire;
  logic [6:0] used;

  // The pending write already owns a slot.
  assign used = 7'(count_q) + 7'(load_en_q);
  assign full = (used == 7'(DEPTH));

`ifdef INSTR_REGISTER_CTRL_STRICT_PRIO_EN
  assign sel0 = bus.req0_valid;
  assign sel1 = bus.req1_valid && !bus.req0_valid;
`else
  logic last_grant_q, last_grant_d;

  // On a tie the requester that did not win last time goes.
  assign sel0 = bus.req0_valid &&
                (!bus.req1_valid || last_grant_q);
  assign sel1 = bus.req1_valid &&
                (!bus.req0_valid || !last_grant_q);
`endif

  assign grant0   = sel0 && !full;
  assign grant1   = sel1 && !full;
  assign pop_fire = bus.pop && (count_q != '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    load_en_d = 1'b0;
    wp_d      = wp_q;
    opc_d     = opc_q;
    a_d       = a_q;
    b_d       = b_q;
`ifndef INSTR_REGISTER_CTRL_STRICT_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    if (grant0 || grant1) begin
      load_en_d = 1'b1;
      wp_d      = wr_ptr_q;
      wr_ptr_d  = nxt(wr_ptr_q);
      opc_d     = grant1 ? bus.req1_opcode : bus.req0_opcode;
      a_d       = grant1 ? bus.req1_operand_a : bus.req0_operand_a;
      b_d       = grant1 ? bus.req1_operand_b : bus.req0_operand_b;
`ifndef INSTR_REGISTER_CTRL_STRICT_PRIO_EN
      last_grant_d = grant1;
`endif
    end
    if (pop_fire) begin
      rd_ptr_d = nxt(rd_ptr_q);
    end
    // Commit lands on the same edge the register captures the data.
    count_d = count_q + 6'(load_en_q) - 6'(pop_fire);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      load_en_q <= 1'b0;
      wp_q      <= '0;
      opc_q     <= ZERO;
      a_q       <= '0;
      b_q       <= '0;
`ifndef INSTR_REGISTER_CTRL_STRICT_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      load_en_q <= load_en_d;
      wp_q      <= wp_d;
      opc_q     <= opc_d;
      a_q       <= a_d;
      b_q       <= b_d;
`ifndef INSTR_REGISTER_CTRL_STRICT_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.req0_ready    = grant0;
  assign bus.req1_ready    = grant1;
  assign bus.load_en       = load_en_q;
  assign bus.write_pointer = wp_q;
  assign bus.opcode        = opc_q;
  assign bus.operand_a     = a_q;
  assign bus.operand_b     = b_q;
  assign bus.read_pointer  = rd_ptr_q;
  assign bus.pop_valid     = (count_q != '0);
  assign bus.count         = count_q;

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Self-checking bench for instr_register_ctrl: reference model and
// scoreboard on the negedge plus directed steps in one initial block.
module tb_instr_register_ctrl;
  import instr_register_pkg::*;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_register_ctrl_if bus ();

  instr_register_ctrl #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  function automatic void check(string tag, logic [31:0] obs,
                                logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  typedef struct {
    address_t wp;
    instr_t   ins;
  } wr_t;

  // Register contents as the instruction register would hold them.
  instr_t mem [DEPTH];
  wr_t    wq [$];
  instr_t cq [$];

  int       m_count;
  bit       m_load;
  address_t m_wp;
  address_t m_rp;
  bit       m_last;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_count = 0;
      m_load  = 0;
      m_wp    = '0;
      m_rp    = '0;
      m_last  = 1;
      wq.delete();
      cq.delete();
    end else begin
      bit full, e0, e1, pf;
      wr_t w;
      instr_t c;
      full = (m_count + int'(m_load)) == DEPTH;
      e0 = bus.req0_valid && !full &&
           (!bus.req1_valid || m_last);
      e1 = bus.req1_valid && !full &&
           (!bus.req0_valid || !m_last);
      check("m_ready0", 32'(bus.req0_ready), 32'(e0));
      check("m_ready1", 32'(bus.req1_ready), 32'(e1));
      check("m_count", 32'(bus.count), 32'(m_count));
      check("m_pop_valid", 32'(bus.pop_valid), 32'(m_count != 0));
      check("m_rd_ptr", 32'(bus.read_pointer), 32'(m_rp));
      check("m_load_en", 32'(bus.load_en), 32'(m_load));
      pf = bus.pop && (m_count != 0);
      if (pf) begin
        if (cq.size() == 0) check("m_cq_empty", 32'(1), 32'(0));
        else begin
          c = cq.pop_front();
          check("m_pop_opc", 32'(mem[bus.read_pointer].opc),
                32'(c.opc));
          check("m_pop_a", mem[bus.read_pointer].op_a, c.op_a);
          check("m_pop_b", mem[bus.read_pointer].op_b, c.op_b);
        end
      end
      if (bus.load_en) begin
        if (wq.size() == 0) check("m_wq_empty", 32'(1), 32'(0));
        else begin
          w = wq.pop_front();
          check("m_wr_ptr", 32'(bus.write_pointer), 32'(w.wp));
          check("m_wr_opc", 32'(bus.opcode), 32'(w.ins.opc));
          check("m_wr_a", bus.operand_a, w.ins.op_a);
          check("m_wr_b", bus.operand_b, w.ins.op_b);
          cq.push_back(w.ins);
        end
        mem[bus.write_pointer] = '{bus.opcode, bus.operand_a,
                                   bus.operand_b};
      end
      m_count = m_count + int'(m_load) - int'(pf);
      m_load  = e0 || e1;
      if (e0 || e1) begin
        w.wp = m_wp;
        if (e1) w.ins = '{bus.req1_opcode, bus.req1_operand_a,
                          bus.req1_operand_b};
        else    w.ins = '{bus.req0_opcode, bus.req0_operand_a,
                          bus.req0_operand_b};
        wq.push_back(w);
        m_wp   = (int'(m_wp) == DEPTH - 1) ? '0 : m_wp + 5'd1;
        m_last = e1;
      end
      if (pf) m_rp = (int'(m_rp) == DEPTH - 1) ? '0 : m_rp + 5'd1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_zero(string p);
    check({p, "_load_en"}, 32'(bus.load_en), 0);
    check({p, "_wp"}, 32'(bus.write_pointer), 0);
    check({p, "_opc"}, 32'(bus.opcode), 32'(ZERO));
    check({p, "_a"}, bus.operand_a, 0);
    check({p, "_b"}, bus.operand_b, 0);
    check({p, "_rp"}, 32'(bus.read_pointer), 0);
    check({p, "_pop_valid"}, 32'(bus.pop_valid), 0);
    check({p, "_count"}, 32'(bus.count), 0);
    check({p, "_ready0"}, 32'(bus.req0_ready), 0);
    check({p, "_ready1"}, 32'(bus.req1_ready), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.pop = 1'b0;
    #1;
    chk_zero("rst");
    repeat (2) cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_opcode = ZERO;
    bus.req0_operand_a = '0;
    bus.req0_operand_b = '0;
    bus.req1_valid = 1'b0;
    bus.req1_opcode = ZERO;
    bus.req1_operand_a = '0;
    bus.req1_operand_b = '0;
    bus.pop = 1'b0;

    // Single ADD: latency to load_en and pop_valid.
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_opcode = ADD;
    bus.req0_operand_a = 5;
    bus.req0_operand_b = 3;
    smp();
    check("t1_ready0", 32'(bus.req0_ready), 1);
    cyc();
    bus.req0_valid = 1'b0;
    smp();
    check("t1_load_en", 32'(bus.load_en), 1);
    check("t1_wp", 32'(bus.write_pointer), 0);
    check("t1_pop_valid_lo", 32'(bus.pop_valid), 0);
    cyc();
    smp();
    check("t1_pop_valid", 32'(bus.pop_valid), 1);
    check("t1_rp", 32'(bus.read_pointer), 0);
    check("t1_opc", 32'(mem[bus.read_pointer].opc), 32'(ADD));
    check("t1_count", 32'(bus.count), 1);
    cyc();
    bus.pop = 1'b1;
    cyc();
    bus.pop = 1'b0;
    smp();
    check("t1_count_after", 32'(bus.count), 0);
    check("t1_rp_after", 32'(bus.read_pointer), 1);

    // Round-robin with both requesters held valid.
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_opcode = SUB;
    bus.req0_operand_a = 7;
    bus.req0_operand_b = 2;
    bus.req1_valid = 1'b1;
    bus.req1_opcode = MULT;
    bus.req1_operand_a = 4;
    bus.req1_operand_b = 6;
    for (int i = 0; i < 4; i++) begin
      smp();
      check("t2_ready0", 32'(bus.req0_ready), 32'(i % 2 == 0));
      check("t2_ready1", 32'(bus.req1_ready), 32'(i % 2 == 1));
      if (i > 0) check("t2_wp", 32'(bus.write_pointer), i - 1);
      cyc();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    smp();
    check("t2_wp3", 32'(bus.write_pointer), 3);
    check("t2_opc3", 32'(bus.opcode), 32'(MULT));
    cyc();
    smp();
    check("t2_count4", 32'(bus.count), 4);
    cyc();
    bus.pop = 1'b1;
    repeat (4) cyc();
    bus.pop = 1'b0;
    smp();
    check("t2_count0", 32'(bus.count), 0);
    check("t2_rp4", 32'(bus.read_pointer), 4);

    // Pop while empty is ignored.
    do_reset();
    bus.pop = 1'b1;
    smp();
    check("t5_pop_valid", 32'(bus.pop_valid), 0);
    cyc();
    smp();
    check("t5_rp", 32'(bus.read_pointer), 0);
    check("t5_count", 32'(bus.count), 0);
    cyc();
    bus.pop = 1'b0;

    // Fill all entries, full back-pressure, pop reopens, wrap to 0.
    do_reset();
    bus.req0_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.req0_opcode = opcode_t'(4'(i % 8));
      bus.req0_operand_a = i;
      bus.req0_operand_b = 100 + i;
      smp();
      check("t3_fill_ready", 32'(bus.req0_ready), 1);
      cyc();
    end
    bus.req0_opcode = DIV;
    bus.req0_operand_a = 99;
    bus.req0_operand_b = -1;
    smp();
    check("t3_full_ready_a", 32'(bus.req0_ready), 0);
    check("t3_count31", 32'(bus.count), 31);
    cyc();
    smp();
    check("t3_full_ready_b", 32'(bus.req0_ready), 0);
    check("t3_count32", 32'(bus.count), 32);
    cyc();
    bus.pop = 1'b1;
    smp();
    check("t3_pop_cycle_ready", 32'(bus.req0_ready), 0);
    cyc();
    bus.pop = 1'b0;
    smp();
    check("t3_reopen_ready", 32'(bus.req0_ready), 1);
    check("t3_count_pop", 32'(bus.count), 31);
    cyc();
    bus.req0_valid = 1'b0;
    smp();
    check("t3_wrap_load", 32'(bus.load_en), 1);
    check("t3_wrap_wp", 32'(bus.write_pointer), 0);
    cyc();
    smp();
    check("t3_refull", 32'(bus.count), 32);
    cyc();
    bus.pop = 1'b1;
    repeat (DEPTH) cyc();
    bus.pop = 1'b0;
    smp();
    check("t3_drained", 32'(bus.count), 0);
    check("t3_rp_wrap", 32'(bus.read_pointer), 1);

    // Commit and pop in the same cycle at count 5.
    do_reset();
    bus.req1_valid = 1'b1;
    bus.req1_opcode = PASSA;
    bus.req1_operand_a = 1;
    bus.req1_operand_b = 2;
    repeat (5) begin
      smp();
      cyc();
    end
    bus.req1_valid = 1'b0;
    smp();
    cyc();
    smp();
    check("t4_count5", 32'(bus.count), 5);
    check("t4_idle", 32'(bus.load_en), 0);
    cyc();
    bus.req0_valid = 1'b1;
    bus.req0_opcode = ADD;
    bus.req0_operand_a = 10;
    bus.req0_operand_b = 20;
    smp();
    check("t4_ready0", 32'(bus.req0_ready), 1);
    cyc();
    bus.req0_valid = 1'b0;
    bus.pop = 1'b1;
    smp();
    check("t4_load", 32'(bus.load_en), 1);
    check("t4_wp5", 32'(bus.write_pointer), 5);
    check("t4_count_pre", 32'(bus.count), 5);
    cyc();
    bus.pop = 1'b0;
    smp();
    check("t4_count_same", 32'(bus.count), 5);
    check("t4_rp1", 32'(bus.read_pointer), 1);

    // Async reset with a write in flight.
    do_reset();
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.req0_opcode = SUB;
      bus.req0_operand_a = i;
      bus.req0_operand_b = i + 1;
      smp();
      cyc();
    end
    bus.req0_valid = 1'b0;
    smp();
    check("t6_load", 32'(bus.load_en), 1);
    check("t6_count7", 32'(bus.count), 7);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("t6_async");
    cyc();
    cyc();
    reset_n = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_opcode = MOD;
    bus.req0_operand_a = 9;
    bus.req0_operand_b = 4;
    smp();
    check("t6_ready0", 32'(bus.req0_ready), 1);
    cyc();
    bus.req0_valid = 1'b0;
    smp();
    check("t6_load_after", 32'(bus.load_en), 1);
    check("t6_wp0", 32'(bus.write_pointer), 0);
    cyc();
    smp();
    check("t6_count1", 32'(bus.count), 1);
    cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_register_ctrl.md
# instr_register_ctrl

Write/read controller for the 32-entry instruction register. It arbitrates two instruction requesters onto the register's single write port and allocates write addresses in circular order. It tracks occupancy and presents stored instructions to one consumer in FIFO order by driving `read_pointer`. It sits between the requesters and `instr_register`, and drives `load_en`, `write_pointer`, `opcode`, `operand_a`, `operand_b` and `read_pointer` in place of a testbench.

## Interface
- `DEPTH`, default 32: number of register entries used. Legal range 2..32, limited by `address_t`.
- `clk` in, 1: sole clock, rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `req0_valid` in, 1: requester 0 has an instruction.
- `req0_ready` out, 1: requester 0 accepted this cycle.
- `req0_opcode` in, `opcode_t`: requester 0 opcode.
- `req0_operand_a` / `req0_operand_b` in, `operand_t`: requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_opcode`, `req1_operand_a`, `req1_operand_b`: same as requester 0, for requester 1.
- `load_en` out, 1: write strobe to the instruction register.
- `write_pointer` out, `address_t`: write address.
- `opcode` out, `opcode_t`: write data.
- `operand_a` / `operand_b` out, `operand_t`: write data.
- `read_pointer` out, `address_t`: head-of-queue address.
- `pop_valid` out, 1: the head entry at `read_pointer` is written and readable.
- `pop` in, 1: consumer takes the head entry.
- `count` out, 6 bits: committed entries, 0..DEPTH.

## Operation
- Internal state:
  - `wr_ptr`: next allocation address.
  - `rd_ptr`: head address, drives `read_pointer`.
  - `count`.
  - `last_grant`: 1 bit.
  - Write-stage register: `load_en`, `write_pointer`, payload.
- Free slots: `free = DEPTH - count - load_en`. The pending write is counted as used.
- Arbitration is combinational:
  - If only one `reqN_valid` is high, it is the candidate.
  - If both are high, the requester not equal to `last_grant` wins.
  - `reqN_ready = candidate_N && free != 0`.
  - `ready` may depend on `valid`.
  - A requester must hold `valid` and its payload stable until `ready`.
- Grant: when `reqN_valid && reqN_ready`:
  - On the next edge, the write stage loads `load_en=1`, `write_pointer=wr_ptr`, and requester N's payload.
  - `wr_ptr` advances. It wraps from DEPTH-1 to 0.
  - `last_grant` becomes N.
- No grant: on the next edge `load_en=0`. The payload outputs hold their last values.
- Commit: in any cycle with `load_en=1`, `count` increments at the edge. That edge is the one on which the register captures the data.
- Pop: when `pop && pop_valid`, `rd_ptr` advances with wrap and `count` decrements. A `pop` while `pop_valid=0` is ignored.
- Commit and pop in the same cycle leave `count` unchanged. Both pointers still move.
- `pop_valid = (count != 0)`.
- `instruction_word` from the register is combinational on `read_pointer`. The consumer samples it while `pop_valid` is high.

## Timing
- Reset value of every output:
  - `load_en=0`, `write_pointer=0`, `opcode=ZERO`, `operand_a=0`, `operand_b=0`.
  - `read_pointer=0`, `pop_valid=0`, `count=0`.
  - `req0_ready=0` and `req1_ready=0` (no `valid` is seen during reset).
  - Internally `last_grant=1`, so requester 0 wins the first tie.
- Request-to-commit latency:
  - Handshake in cycle T.
  - `load_en` high during T+1.
  - Entry counted and `pop_valid` high from T+2.
- Throughput is one grant per cycle. Back-to-back grants alternate between requesters when both are held valid.
- Full boundary:
  - When `count + load_en == DEPTH`, both readies are 0.
  - A pop in cycle T re-enables `ready` in T+1.
- Empty boundary: `pop_valid` stays low until the first commit edge. There is no bypass from request to pop.
- Wrap: DEPTH=32 wraps 31→0 on both pointers. For DEPTH<32, addresses DEPTH..31 are never driven.
- Asynchronous reset mid-operation:
  - All state returns to reset values immediately.
  - A write in flight (`load_en=1`) is abandoned and not counted.

## Configuration
- `INSTR_REGISTER_CTRL_STRICT_PRIO_EN` defined: fixed priority. Requester 0 always wins a tie, and `last_grant` is unused.
- Undefined (default): round-robin as specified under Operation.

## Test plan
- Reset, then requester 0 sends ADD a=5 b=3 -> `load_en`=1 with `write_pointer`=0 one cycle after the handshake; `pop_valid`=1 two cycles after; `read_pointer`=0 and `instruction_word.opc`=ADD.
- Both requesters held valid for 4 cycles -> grants in order 0,1,0,1; `write_pointer` 0,1,2,3; `count` reaches 4.
- Fill 32 entries with no pop -> both readies 0 while `count`=32; one pop -> `ready` returns next cycle; the next write goes to address 0 (wrap).
- Pop and grant commit in the same cycle at `count`=5 -> `count` stays 5; `read_pointer` and `write_pointer` both advance.
- Pop at `count`=0 -> no change; `read_pointer` stays 0.
- Assert `reset_n` low while `load_en`=1 and `count`=7 -> all outputs read zero/ZERO immediately; after release, the first grant writes address 0.
